// File: rtl/sram_s2_arbiter_if.sv
// Requester-side port of the s2 SRAM arbiter: one command channel plus its read return.
interface sram_s2_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, write, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, write, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_s2_arbiter.sv
// Two-requester round-robin arbiter onto SRAM port s2 with bounded bursts,
// a registered command stage and tagged read return.
module sram_s2_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  sram_s2_arbiter_if.slave    a,
  sram_s2_arbiter_if.slave    b,
  output logic [ADDR_W-1:0]   sram_address,
  output logic                sram_chipselect,
  output logic                sram_clken,
  output logic                sram_write,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic [DATA_W/8-1:0] sram_byteenable,
  input  logic [DATA_W-1:0]   sram_readdata
);
  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t      state;
  logic        run;
  logic        last_owner;   // 0 = A, 1 = B
  logic [7:0]  burst_cnt;
  logic        gnt_a, gnt_b;
  logic        burst_ok;
  logic        cmd_id;       // requester of the command currently on s2

  logic [READ_LATENCY-1:0] tag_vld, tag_id;
  logic [DATA_W-1:0]       a_rdata_q, b_rdata_q;

  assign burst_ok   = burst_cnt < MAX_B;
  assign sram_clken = run;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (run) begin
      case (state)
        IDLE: begin
          if (a.req && b.req) begin
            gnt_a = last_owner;
            gnt_b = !last_owner;
          end else begin
            gnt_a = a.req;
            gnt_b = b.req;
          end
        end
        // Expiry beats the owner's request; handover costs no idle cycle.
        OWN_A: begin
          if (a.req && (burst_ok || !b.req)) gnt_a = 1'b1;
          else                               gnt_b = b.req;
        end
        OWN_B: begin
          if (b.req && (burst_ok || !a.req)) gnt_b = 1'b1;
          else                               gnt_a = a.req;
        end
        default: ;
      endcase
    end
  end

  assign a.gnt = gnt_a;
  assign b.gnt = gnt_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      run        <= 1'b0;
      last_owner <= 1'b1;
      burst_cnt  <= 8'd0;
    end else begin
      run <= 1'b1;
      if (gnt_a) begin
        if (state == OWN_A) begin
          if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
        end else begin
          if (state == OWN_B) last_owner <= 1'b1;
          state     <= OWN_A;
          burst_cnt <= 8'd1;
        end
      end else if (gnt_b) begin
        if (state == OWN_B) begin
          if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
        end else begin
          if (state == OWN_A) last_owner <= 1'b0;
          state     <= OWN_B;
          burst_cnt <= 8'd1;
        end
      end else if (state != IDLE) begin
        last_owner <= (state == OWN_B);
        state      <= IDLE;
        burst_cnt  <= 8'd0;
      end
    end
  end

  // Command stage: address/data/byteenable hold their last value when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_chipselect <= 1'b0;
      sram_write      <= 1'b0;
      sram_address    <= '0;
      sram_writedata  <= '0;
      sram_byteenable <= '0;
      cmd_id          <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      sram_chipselect <= 1'b1;
      sram_write      <= gnt_b ? b.write : a.write;
      sram_address    <= gnt_b ? b.addr  : a.addr;
      sram_writedata  <= gnt_b ? b.wdata : a.wdata;
      sram_byteenable <= gnt_b ? b.be    : a.be;
      cmd_id          <= gnt_b;
    end else begin
      sram_chipselect <= 1'b0;
      sram_write      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= sram_chipselect && !sram_write;
      tag_id[0]  <= cmd_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign a.rvalid = tag_vld[READ_LATENCY-1] && !tag_id[READ_LATENCY-1];
  assign b.rvalid = tag_vld[READ_LATENCY-1] &&  tag_id[READ_LATENCY-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a.rvalid) a_rdata_q <= sram_readdata;
      if (b.rvalid) b_rdata_q <= sram_readdata;
    end
  end

  // The rvalid cycle forwards s2 readdata directly so grant-to-data stays
  // 1+READ_LATENCY; the captured copy holds it until the next return.
  assign a.rdata = a.rvalid ? sram_readdata : a_rdata_q;
  assign b.rdata = b.rvalid ? sram_readdata : b_rdata_q;
endmodule

// File: tb/tb_sram_s2_arbiter.sv
// Directed bench: dut0 at default parameters, dut1 with READ_LATENCY=2, MAX_BURST=4.
module tb_sram_s2_arbiter;
  logic clk, reset_n;
  int   n_chk = 0, n_err = 0;

  sram_s2_arbiter_if #(.ADDR_W(14), .DATA_W(32)) a0 ();
  sram_s2_arbiter_if #(.ADDR_W(14), .DATA_W(32)) b0 ();
  sram_s2_arbiter_if #(.ADDR_W(14), .DATA_W(32)) a1 ();
  sram_s2_arbiter_if #(.ADDR_W(14), .DATA_W(32)) b1 ();

  logic [13:0] s0_addr, s1_addr;
  logic        s0_cs, s0_clken, s0_wr, s1_cs, s1_clken, s1_wr;
  logic [31:0] s0_wd, s0_rd, s1_wd, s1_rd, s1_rd_p;
  logic [3:0]  s0_be, s1_be;
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];

  sram_s2_arbiter dut0 (
    .clk(clk), .reset_n(reset_n), .a(a0), .b(b0),
    .sram_address(s0_addr), .sram_chipselect(s0_cs), .sram_clken(s0_clken),
    .sram_write(s0_wr), .sram_writedata(s0_wd), .sram_byteenable(s0_be),
    .sram_readdata(s0_rd));

  sram_s2_arbiter #(.READ_LATENCY(2), .MAX_BURST(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .a(a1), .b(b1),
    .sram_address(s1_addr), .sram_chipselect(s1_cs), .sram_clken(s1_clken),
    .sram_write(s1_wr), .sram_writedata(s1_wd), .sram_byteenable(s1_be),
    .sram_readdata(s1_rd));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s2 models: latency 1 for dut0, 2 for dut1, byte-enabled writes.
  always @(posedge clk) begin
    if (s0_cs) begin
      if (s0_wr) begin
        for (int k = 0; k < 4; k++)
          if (s0_be[k]) mem0[s0_addr[7:0]][8*k +: 8] <= s0_wd[8*k +: 8];
      end else s0_rd <= mem0[s0_addr[7:0]];
    end
    if (s1_cs) begin
      if (s1_wr) begin
        for (int k = 0; k < 4; k++)
          if (s1_be[k]) mem1[s1_addr[7:0]][8*k +: 8] <= s1_wd[8*k +: 8];
      end else s1_rd_p <= mem1[s1_addr[7:0]];
    end
    s1_rd <= s1_rd_p;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem0[k] <= 32'h0;
      mem1[k] <= 32'h0;
    end
    mem0[1] <= 32'h1111_1111;
    mem0[2] <= 32'h2222_2222;
    mem1[1] <= 32'hAAAA_0001;
    mem1[2] <= 32'hBBBB_0002;
    s0_rd = '0; s1_rd = '0; s1_rd_p = '0;
    {a0.req, a0.write, a0.addr, a0.wdata, a0.be} = '0;
    {b0.req, b0.write, b0.addr, b0.wdata, b0.be} = '0;
    {a1.req, a1.write, a1.addr, a1.wdata, a1.be} = '0;
    {b1.req, b1.write, b1.addr, b1.wdata, b1.be} = '0;

    // Reset with a_req held
    reset_n = 1'b0;
    a0.req = 1'b1; a0.be = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt",    a0.gnt,    0);
    chk("rst_cs",     s0_cs,     0);
    chk("rst_clken",  s0_clken,  0);
    chk("rst_addr",   s0_addr,   0);
    chk("rst_rvalid", a0.rvalid, 0);
    chk("rst_rdata",  a0.rdata,  0);
    @(negedge clk); reset_n = 1'b1; #1;
    chk("rel_gnt", a0.gnt, 0);
    @(posedge clk); #1;
    chk("e1_cs",    s0_cs,    0);
    chk("e1_wr",    s0_wr,    0);
    chk("e1_clken", s0_clken, 1);
    chk("e2_gnt",   a0.gnt,   1);

    // A write then read-back
    @(negedge clk);
    a0.write = 1'b1; a0.addr = 14'h0010; a0.wdata = 32'hDEADBEEF; a0.be = 4'hF; #1;
    chk("wr_gnt", a0.gnt, 1);
    @(negedge clk); #1;
    chk("wr_cs",   s0_cs,   1);
    chk("wr_wr",   s0_wr,   1);
    chk("wr_addr", s0_addr, 14'h0010);
    chk("wr_data", s0_wd,   32'hDEADBEEF);
    a0.write = 1'b0; #1;
    chk("rd_gnt", a0.gnt, 1);
    @(negedge clk); a0.req = 1'b0; #1;
    chk("rd_cs",   s0_cs,     1);
    chk("rd_wr",   s0_wr,     0);
    chk("rd_rv1",  a0.rvalid, 0);
    @(negedge clk); #1;
    chk("rd_rv2",    a0.rvalid, 1);
    chk("rd_data",   a0.rdata,  32'hDEADBEEF);
    chk("rd_brv",    b0.rvalid, 0);
    @(negedge clk); #1;
    chk("rd_rv3",    a0.rvalid, 0);
    chk("rd_hold",   a0.rdata,  32'hDEADBEEF);
    chk("idle_cs",   s0_cs,     0);
    chk("idle_addr", s0_addr,   14'h0010);

    // B partial write
    b0.req = 1'b1; b0.write = 1'b1; b0.addr = 14'h0020; b0.wdata = 32'h12345678; b0.be = 4'hF; #1;
    chk("pw_gnt1", b0.gnt, 1);
    @(negedge clk); b0.wdata = 32'hAAAABBBB; b0.be = 4'h3; #1;
    chk("pw_gnt2", b0.gnt, 1);
    @(negedge clk); b0.write = 1'b0; #1;
    chk("pw_gnt3", b0.gnt, 1);
    @(negedge clk); b0.req = 1'b0; #1;
    chk("pw_be",   s0_be,   4'h3);
    @(negedge clk); #1;
    chk("pw_rv",   b0.rvalid, 1);
    chk("pw_data", b0.rdata,  32'h1234BBBB);
    chk("pw_arv",  a0.rvalid, 0);

    // B alone for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); b0.req = 1'b1; #1;
      chk("b10_gnt", b0.gnt, 1);
      chk("b10_agnt", a0.gnt, 0);
    end
    @(negedge clk); b0.req = 1'b0;
    repeat (3) @(negedge clk);

    // Alternating single reads A@1, B@2
    a0.addr = 14'h0001; b0.addr = 14'h0002; a0.write = 1'b0; b0.write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      a0.req = (i < 4) && (i % 2 == 0);
      b0.req = (i < 4) && (i % 2 == 1);
      #1;
      if (i < 4) chk("alt_gnt", (i % 2 == 1) ? b0.gnt : a0.gnt, 1);
      if (i >= 2) begin
        chk("alt_arv", a0.rvalid, ((i - 2) % 2 == 0));
        chk("alt_brv", b0.rvalid, ((i - 2) % 2 == 1));
        if ((i - 2) % 2 == 0) chk("alt_adata", a0.rdata, 32'h1111_1111);
        else                  chk("alt_bdata", b0.rdata, 32'h2222_2222);
      end
    end
    @(negedge clk); a0.req = 1'b0; b0.req = 1'b0;

    // dut1: both requesting from IDLE, MAX_BURST=4, 3-cycle read return
    a1.addr = 14'h0001; b1.addr = 14'h0002;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      a1.req = (i < 12); b1.req = (i < 12); #1;
      if (i < 12) begin
        chk("bur_agnt", a1.gnt, ((i / 4) % 2 == 0));
        chk("bur_bgnt", b1.gnt, ((i / 4) % 2 == 1));
      end
      if (i >= 3) begin
        chk("bur_arv", a1.rvalid, (((i - 3) / 4) % 2 == 0));
        chk("bur_brv", b1.rvalid, (((i - 3) / 4) % 2 == 1));
        if (((i - 3) / 4) % 2 == 0) chk("bur_adata", a1.rdata, 32'hAAAA_0001);
        else                        chk("bur_bdata", b1.rdata, 32'hBBBB_0002);
      end
    end

    // dut1 single-read latency
    @(negedge clk); a1.req = 1'b1; #1;
    chk("l2_gnt", a1.gnt, 1);
    @(negedge clk); a1.req = 1'b0; #1;
    chk("l2_rv1", a1.rvalid, 0);
    @(negedge clk); #1;
    chk("l2_rv2", a1.rvalid, 0);
    @(negedge clk); #1;
    chk("l2_rv3", a1.rvalid, 1);
    chk("l2_data", a1.rdata, 32'hAAAA_0001);

    // Reset with two reads in flight
    @(negedge clk); a1.req = 1'b1;
    @(negedge clk);
    @(negedge clk); a1.req = 1'b0;
    reset_n = 1'b0; #1;
    chk("mr_rv",    a1.rvalid, 0);
    chk("mr_cs",    s1_cs,     0);
    chk("mr_rdata", a1.rdata,  0);
    chk("mr_clken", s1_clken,  0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("mr_norv", {a1.rvalid, b1.rvalid}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
